// File: rtl/spi_pkg.sv
// Shared SPI constants and types for the mode-0 slave endpoint.
package spi_pkg;

    localparam int SPI_DATA_W  = 8;
    localparam int SYNC_STAGES = 2;

    // Mode 0: SCLK idles low, data sampled on rise, changed on fall.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        WAIT_IDLE = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle edge strobes.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully oversampled in the clk domain, with a one-entry transmit buffer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              frame_err,
    output logic              tx_underrun
);

    localparam int CNT_W = $clog2(DATA_W);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .reset(reset), .d(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b1)) u_cs (.clk(clk), .reset(reset), .d(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (.clk(clk), .reset(reset), .d(mosi),
        .level(mosi_lvl), .rise(), .fall());

    spi_state_t        state, state_d;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift, rx_shift_d, tx_shift, tx_shift_d, rx_data_d, tx_buf;
    logic              reload_pending, reload_d, tx_full, load_pt;
    logic              rx_valid_d, frame_err_d, underrun_d;
    logic [SYNC_STAGES:0] settle_pipe;

    // The cs_n synchronizer reset value does not reflect the pin; wait for it to refill
    // so a reset-time cs_n low cannot look like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) settle_pipe <= '0;
        else       settle_pipe <= {settle_pipe[SYNC_STAGES-1:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= WAIT_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        rx_shift_d  = rx_shift;
        tx_shift_d  = tx_shift;
        reload_d    = reload_pending;
        rx_data_d   = rx_data;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        underrun_d  = 1'b0;
        load_pt     = 1'b0;
        case (state)
            WAIT_IDLE: if (settle_pipe[SYNC_STAGES] && cs_lvl) state_d = IDLE;
            IDLE: if (cs_fall) begin
                state_d   = SHIFT;
                load_pt   = 1'b1;
                bit_cnt_d = '0;
                reload_d  = 1'b0;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift[DATA_W-2:0], mosi_lvl};
                    if (bit_cnt == CNT_W'(DATA_W-1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (reload_pending) begin
                        load_pt  = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift[DATA_W-2:0], 1'b0};
                    end
                end
                // A word completing on this same cycle leaves bit_cnt_d at 0: no error.
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_d != '0);
                    bit_cnt_d   = '0;
                    reload_d    = 1'b0;
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
        if (load_pt) begin
            tx_shift_d = tx_full ? tx_buf : '0;
            underrun_d = ~tx_full;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            reload_pending <= 1'b0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            frame_err      <= 1'b0;
            tx_underrun    <= 1'b0;
            tx_buf         <= '0;
            tx_full        <= 1'b0;
            miso           <= 1'b0;
        end else begin
            bit_cnt        <= bit_cnt_d;
            rx_shift       <= rx_shift_d;
            tx_shift       <= tx_shift_d;
            reload_pending <= reload_d;
            rx_data        <= rx_data_d;
            rx_valid       <= rx_valid_d;
            frame_err      <= frame_err_d;
            tx_underrun    <= underrun_d;
            miso           <= (state == SHIFT) ? tx_shift[DATA_W-1] : 1'b0;
            // A load point consumes only a full buffer; a same-cycle load into an
            // empty buffer is kept for the next word.
            if (load_pt && tx_full) tx_full <= 1'b0;
            if (tx_load && !tx_full) begin
                tx_full <= 1'b1;
                tx_buf  <= tx_data;
            end
        end
    end

    assign tx_ready = ~tx_full;
    assign busy     = (state == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged mode-0 master, rx scoreboard and pulse monitor.
module tb_spi_slave;
    localparam int W = 8;
    localparam int HALF = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic         miso;
    logic [W-1:0] tx_data = '0;
    logic         tx_load = 1'b0;
    logic         tx_ready, rx_valid, busy, frame_err, tx_underrun;
    logic [W-1:0] rx_data;

    int errors = 0, checks = 0;
    int rx_cnt = 0, ferr_cnt = 0, start_ur = 0, busy_bad = 0;
    bit in_start = 1'b0, watch_busy = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mi;

    spi_slave #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .busy(busy), .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the rx scoreboard on every rx_valid and counts status pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_valid) begin
                rx_cnt++;
                if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, rx_data}, 32'hdead);
                else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            if (frame_err) ferr_cnt++;
            if (tx_underrun && in_start) start_ur++;
            if (busy && watch_busy) busy_bad++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [W-1:0] d);
        tx_data = d; tx_load = 1'b1;
        cyc(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        in_start = 1'b1; cs_n = 1'b0;
        cyc(HALF);
        in_start = 1'b0;
    endtask

    task automatic cs_high();
        cyc(HALF);
        cs_n = 1'b1;
        cyc(2 * HALF);
    endtask

    // Shifts nbits MSB-first; miso is sampled at each sclk rise.
    task automatic send(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] got);
        got = '0;
        for (int i = W - 1; i >= W - nbits; i--) begin
            mosi = mo[i];
            cyc(HALF);
            sclk = 1'b1; got[i] = miso;
            cyc(HALF);
            sclk = 1'b0;
        end
    endtask

    initial begin
        cyc(5);
        reset = 1'b0;
        cyc(10);
        chk("rst_miso", {31'd0, miso}, 0);
        chk("rst_tx_ready", {31'd0, tx_ready}, 1);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_pulses", {29'd0, rx_valid, frame_err, tx_underrun}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // Single word
        load(8'h3C);
        chk("single_tx_ready_low", {31'd0, tx_ready}, 0);
        exp_q.push_back(8'hA5);
        cs_low();
        chk("single_tx_ready_high", {31'd0, tx_ready}, 1);
        chk("single_busy", {31'd0, busy}, 1);
        send(8'hA5, 8, mi);
        chk("single_miso", {24'd0, mi}, 32'h3C);
        cs_high();
        chk("single_start_underrun", start_ur, 0);

        // Burst of two words, refill after first consumption
        load(8'h11);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        cs_low();
        begin
            int t = 0;
            while (!tx_ready && t < 40) begin cyc(1); t++; end
            chk("burst_refill_timeout", {31'd0, tx_ready}, 1);
        end
        load(8'h22);
        send(8'h5A, 8, mi);
        chk("burst_miso0", {24'd0, mi}, 32'h11);
        send(8'hC3, 8, mi);
        chk("burst_miso1", {24'd0, mi}, 32'h22);
        cs_high();
        chk("burst_rx_cnt", rx_cnt, 3);

        // Underrun
        exp_q.push_back(8'hFF);
        cs_low();
        send(8'hFF, 8, mi);
        chk("underrun_miso", {24'd0, mi}, 0);
        cs_high();
        chk("underrun_pulse", start_ur, 1);
        chk("underrun_rx_data", {24'd0, rx_data}, 32'hFF);

        // Abort after 5 bits
        cs_low();
        send(8'h3A, 5, mi);
        cs_high();
        chk("abort_frame_err", ferr_cnt, 1);
        chk("abort_rx_cnt", rx_cnt, 4);
        chk("abort_rx_data_held", {24'd0, rx_data}, 32'hFF);
        exp_q.push_back(8'h81);
        cs_low();
        send(8'h81, 8, mi);
        cs_high();
        chk("abort_next_rx_cnt", rx_cnt, 5);
        chk("abort_next_frame_err", ferr_cnt, 1);

        // Reset mid-frame with cs_n held low
        load(8'h6B);
        cs_low();
        send(8'hF0, 3, mi);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("mrst_tx_ready", {31'd0, tx_ready}, 1);
        chk("mrst_rx_data", {24'd0, rx_data}, 0);
        chk("mrst_busy_miso", {30'd0, busy, miso}, 0);
        watch_busy = 1'b1;
        send(8'hF0, 4, mi);
        chk("mrst_miso_quiet", {24'd0, mi}, 0);
        cs_high();
        watch_busy = 1'b0;
        chk("mrst_busy_never", busy_bad, 0);
        chk("mrst_no_rx", rx_cnt, 5);
        chk("mrst_no_frame_err", ferr_cnt, 1);
        exp_q.push_back(8'h42);
        cs_low();
        send(8'h42, 8, mi);
        cs_high();
        chk("mrst_next_rx_cnt", rx_cnt, 6);

        // Load while full is ignored
        load(8'h77);
        load(8'h99);
        exp_q.push_back(8'h00);
        cs_low();
        send(8'h00, 8, mi);
        chk("ignored_load_miso", {24'd0, mi}, 32'h77);
        cs_high();

        begin
            int t = 0;
            while (exp_q.size() != 0 && t < 50) begin cyc(1); t++; end
            chk("scoreboard_drained", exp_q.size(), 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI mode-0 slave endpoint that consumes the SCLK / chip-select / MOSI lines driven by the SPI master and returns data on MISO. All SPI pins are oversampled in the single system clock domain (no logic clocked by SCLK). The block sits directly downstream of the master, one instance per chip-select line. It exposes a byte-wide receive strobe and a one-entry transmit buffer to local logic.

## Interface
- DATA_W, 8, bits per SPI word, transferred MSB first
- clk  in  1  system clock; must be ≥ 8× SCLK frequency
- reset  in  1  synchronous, active-high
- sclk  in  1  SPI clock from master, asynchronous to clk, idles low
- cs_n  in  1  chip select for this slave, active low, asynchronous
- mosi  in  1  serial data from master
- miso  out  1  serial data to master; driven 0 when not selected (no tristate)
- tx_data  in  DATA_W  next word to transmit
- tx_load  in  1  write tx_data into transmit buffer; honoured only when tx_ready=1
- tx_ready  out  1  transmit buffer empty
- rx_data  out  DATA_W  last completed received word; held until next completion
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  state is SHIFT
- frame_err  out  1  one-cycle pulse, cs_n deasserted mid-word
- tx_underrun  out  1  one-cycle pulse, word load found buffer empty (0 shifted out)

## Operation
- sclk, cs_n and mosi each pass through a 2-flop synchronizer, followed by a previous-value register. Rise and fall strobes are single-cycle.
- Synchronizer reset values: sclk 0, cs_n 1, mosi 0.
- States: IDLE, SHIFT, WAIT_IDLE.
  - IDLE → SHIFT on cs_n fall. In the same cycle: tx buffer moves into tx_shift (or 0 plus tx_underrun if empty), bit_cnt=0.
  - SHIFT, sclk rise: rx_shift ← {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt+1.
  - SHIFT, sclk rise with bit_cnt==DATA_W-1: rx_data ← completed word, rx_valid=1, bit_cnt ← 0, reload_pending=1.
  - SHIFT, sclk fall: if reload_pending, tx_shift ← buffer (underrun rule as above) and reload_pending=0. Otherwise tx_shift shifts left by 1.
  - SHIFT → IDLE on cs_n rise. frame_err=1 if bit_cnt≠0. Partial rx bits are discarded and no rx_valid is produced.
  - After reset the state is WAIT_IDLE. WAIT_IDLE → IDLE when cs_n_sync is high, so a frame interrupted by reset is never joined mid-word.
- Multiple words per cs_n assertion are supported back-to-back.
- miso = tx_shift[DATA_W-1] in SHIFT, else 0.
- Transmit buffer: one entry.
  - tx_ready=1 when empty.
  - tx_load while tx_ready=0 is ignored; the buffer is not overwritten.
  - The buffer is consumed only at word-load points.
- Simultaneous events:
  - sclk rise completing a word in the same cycle as cs_n rise: the word completes (rx_valid=1), frame_err=0, then IDLE.
  - tx_load in the same cycle as a load point with buffer empty: the load point sees empty (underrun, 0 sent); the new data is stored for the next word.
  - sclk edges outside SHIFT are ignored.

## Timing
- Reset values:
  - Outputs: miso 0, tx_ready 1, rx_data 0, rx_valid 0, busy 0, frame_err 0, tx_underrun 0.
  - Internal: bit_cnt 0, reload_pending 0, state WAIT_IDLE.
- Pin-to-strobe latency: a pin edge first captured at clk edge k produces its strobe during cycle k+1→k+2. The resulting register updates happen at edge k+2.
- rx_valid is high for exactly one cycle, at edge k+2 of the final sclk rise.
- A first-bit MISO change reaches the pin 3 clk edges after the cs_n fall is sampled. The master's first sclk rise must allow for this; ≥ 4 clk cycles is guaranteed adequate.
- tx_ready rises at the cycle the buffer is consumed and falls the cycle after an accepted tx_load.

## Structure
- Package spi_pkg:
  - DATA_W default
  - state enum {IDLE, SHIFT, WAIT_IDLE}
  - SYNC_STAGES=2
  - SPI mode constants shared with the master
- Sub-module spi_sync_edge: synchronizer + edge detector.
  - Parameter: reset value.
  - Outputs: level, rise, fall.
  - Instantiated for sclk, cs_n and mosi (rise/fall of mosi unused).

## Test plan
- Single word: tx_load 0x3C in IDLE, master sends 0xA5 at clk/16 → rx_valid once with rx_data=0xA5, master receives 0x3C, tx_ready 0→1.
- Burst: buffer 0x11, refill 0x22 after first consumption, master sends 0x5A,0xC3 under one cs_n → rx_valid twice (0x5A, 0xC3), miso returns 0x11,0x22.
- Underrun: no tx_load, master sends 0xFF → tx_underrun pulse at cs_n fall, master receives 0x00, rx_data=0xFF.
- Abort: cs_n raised after 5 sclk rises → frame_err pulse, no rx_valid, rx_data keeps old value, next full frame 0x81 received correctly.
- Reset mid-frame: reset after 3 bits with cs_n still low, then 4 more sclk pulses → no rx_valid, state WAIT_IDLE until cs_n high, all outputs at reset values; next frame 0x42 received correctly.
- Ignored load: tx_load 0x77 then tx_load 0x99 while tx_ready=0 → master receives 0x77.
